// File: rtl/polar_pkg.sv
// rtl/polar_pkg.sv - opcodes, FSM states and node-size helpers for the PE write-back stage
package polar_pkg;

  localparam logic [3:0] TYPE1FUN  = 4'd0;
  localparam logic [3:0] TYPE2FUN  = 4'd1;
  localparam logic [3:0] BOTTOMFUN = 4'd2;
  localparam logic [3:0] TYPE3FUN  = 4'd3;

  localparam int INV_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR0  = 2'd1,
    ST_WR1  = 2'd2
  } wb_state_t;

  function automatic logic is_beta(input logic [3:0] op);
    return (op == BOTTOMFUN) || (op == TYPE3FUN);
  endfunction

  function automatic logic inv_pow2(input logic [INV_W-1:0] inv);
    return (inv >= 11'd2) && ((inv & (inv - 11'd1)) == 11'd0);
  endfunction

  function automatic logic entry_legal(input logic [3:0] op, input logic [INV_W-1:0] inv);
    if (is_beta(op))
      return inv_pow2(inv);
    if ((op == TYPE1FUN) || (op == TYPE2FUN))
      return inv_pow2(inv) && (inv >= 11'd4);
    return 1'b0;
  endfunction

  // Lanes taken from each source half; the I_Nv==2 bottom node uses the low half only.
  function automatic logic [INV_W-1:0] keep_lanes(input logic [3:0] op, input logic [INV_W-1:0] inv);
    if (!is_beta(op))
      return inv >> 2;
    if ((op == BOTTOMFUN) && (inv == 11'd2))
      return 11'd2;
    return inv >> 1;
  endfunction

  function automatic logic [INV_W-1:0] mask_lanes(input logic [3:0] op, input logic [INV_W-1:0] inv);
    return is_beta(op) ? inv : (inv >> 2);
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - two-entry FIFO with a look-ahead view of the head after this cycle's push/pop
module wb_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [W-1:0] nxt_head,
  output logic         nxt_empty,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         rd;
  logic [1:0]   count;
  logic [1:0]   count_n;
  logic         rd_n;
  logic         wr_idx;
  logic         do_push;
  logic         do_pop;

  assign do_pop    = pop && (count != 2'd0);
  assign do_push   = push && ((count != 2'd2) || do_pop);
  assign wr_idx    = rd ^ count[0];
  assign count_n   = count + {1'b0, do_push} - {1'b0, do_pop};
  assign rd_n      = rd ^ do_pop;
  assign head      = mem[rd];
  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign nxt_empty = (count_n == 2'd0);

  // The consumer loads its registered outputs from the post-edge head, which may be din itself.
  always_comb begin
    nxt_head = mem[rd_n];
    if ((count == 2'd0) || ((count == 2'd1) && do_pop))
      nxt_head = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      rd    <= 1'b0;
    end else begin
      count <= count_n;
      rd    <= rd_n;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pe_writeback.sv
// rtl/pe_writeback.sv - PE result write-back: FIFO, pack/split FSM, bypass history under PE_WB_BYPASS_EN
module pe_writeback
  import polar_pkg::*;
#(
  parameter int P      = 256,
  parameter int Q      = 6,
  parameter int ADDR_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pe_valid,
  output logic               pe_ready,
  input  logic [2*P*Q-1:0]   pe_data,
  input  logic [3:0]         pe_opcode,
  input  logic [ADDR_W-1:0]  pe_addr,
  input  logic [INV_W-1:0]   pe_inv,
  output logic               wr_en,
  input  logic               wr_ready,
  output logic               wr_beta,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [P*Q-1:0]     wr_data,
  output logic [P-1:0]       wr_mask,
  output logic [2*P*Q-1:0]   byp_data0,
  output logic [2*P*Q-1:0]   byp_data1,
  output logic [3:0]         byp_op0,
  output logic [3:0]         byp_op1,
  output logic [1:0]         byp_vld,
  output logic               busy
);

  localparam int HW       = P * Q;
  localparam int ADDR_LSB = INV_W;
  localparam int OP_LSB   = ADDR_LSB + ADDR_W;
  localparam int DATA_LSB = OP_LSB + 4;
  localparam int EW       = DATA_LSB + 2 * HW;

  wb_state_t state;

  logic          push;
  logic          pop;
  logic          f_full;
  logic          f_empty;
  logic          f_nxt_empty;
  logic [EW-1:0] f_head;
  logic [EW-1:0] f_nxt;

  assign pe_ready = !f_full;
  assign push     = pe_valid && !f_full;
  assign busy     = !f_empty || wr_en;

  wb_fifo2 #(.W(EW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .din       ({pe_data, pe_opcode, pe_addr, pe_inv}),
    .head      (f_head),
    .nxt_head  (f_nxt),
    .nxt_empty (f_nxt_empty),
    .full      (f_full),
    .empty     (f_empty)
  );

  function automatic logic entry_split(input logic [3:0] op, input logic [INV_W-1:0] inv);
    return is_beta(op) && ({21'd0, inv} > 32'(P));
  endfunction

  logic [3:0]       h_op;
  logic [3:0]       n_op;
  logic [INV_W-1:0] h_inv;
  logic [INV_W-1:0] n_inv;
  logic             adv;
  logic             last;
  logic             adv_split;
  logic             fin;
  logic             free;
  logic             load_new;

  assign h_op  = f_head[OP_LSB +: 4];
  assign h_inv = f_head[INV_W-1:0];
  assign n_op  = f_nxt[OP_LSB +: 4];
  assign n_inv = f_nxt[INV_W-1:0];

  // The entry in flight stays at the FIFO head until its last write is taken.
  assign adv       = wr_en && wr_ready;
  assign last      = (state == ST_WR1) || !entry_split(h_op, h_inv);
  assign adv_split = adv && (state == ST_WR0) && entry_split(h_op, h_inv);
  assign fin       = adv && last;
  assign free      = (state == ST_IDLE) || fin;
  assign pop       = fin || ((state == ST_IDLE) && !f_empty && !entry_legal(h_op, h_inv));
  assign load_new  = free && !f_nxt_empty && entry_legal(n_op, n_inv);

  logic [EW-1:0]     src;
  logic [3:0]        s_op;
  logic [ADDR_W-1:0] s_addr;
  logic [INV_W-1:0]  s_inv;
  logic [HW-1:0]     s_lo;
  logic [HW-1:0]     s_hi;
  logic [INV_W-1:0]  keep_cnt;
  logic [INV_W-1:0]  mask_cnt;
  logic [HW-1:0]     keep_m;
  logic [P-1:0]      lane_m;
  logic              b_beta;
  logic [ADDR_W-1:0] b_addr;
  logic [HW-1:0]     b_data;
  logic [P-1:0]      b_mask;

  always_comb begin
    src      = adv_split ? f_head : f_nxt;
    s_op     = src[OP_LSB +: 4];
    s_addr   = src[ADDR_LSB +: ADDR_W];
    s_inv    = src[INV_W-1:0];
    s_lo     = src[DATA_LSB +: HW];
    s_hi     = src[DATA_LSB + HW +: HW];
    keep_cnt = keep_lanes(s_op, s_inv);
    mask_cnt = mask_lanes(s_op, s_inv);
    keep_m   = '0;
    lane_m   = '0;
    for (int i = 0; i < P; i++) begin
      lane_m[i]        = (i < int'(mask_cnt));
      keep_m[i*Q +: Q] = {Q{i < int'(keep_cnt)}};
    end
    b_beta = is_beta(s_op);
    b_addr = s_addr;
    b_data = '0;
    b_mask = '0;
    if (adv_split) begin
      b_addr = s_addr + ADDR_W'(1);
      b_data = s_hi;
      b_mask = '1;
    end else if (entry_split(s_op, s_inv)) begin
      b_data = s_lo;
      b_mask = '1;
    end else if (b_beta && !((s_op == BOTTOMFUN) && (s_inv == 11'd2))) begin
      // Low-half lanes fill the bottom h word lanes, high-half lanes the next h.
      b_data = (s_lo & keep_m) | ((s_hi & keep_m) << (int'(keep_cnt) * Q));
      b_mask = lane_m;
    end else begin
      b_data = ((s_op == TYPE2FUN) ? s_hi : s_lo) & keep_m;
      b_mask = lane_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      wr_en   <= 1'b0;
      wr_beta <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_mask <= '0;
    end else if (adv_split) begin
      state   <= ST_WR1;
      wr_addr <= b_addr;
      wr_data <= b_data;
      wr_mask <= b_mask;
    end else if (free) begin
      if (load_new) begin
        state   <= ST_WR0;
        wr_en   <= 1'b1;
        wr_beta <= b_beta;
        wr_addr <= b_addr;
        wr_data <= b_data;
        wr_mask <= b_mask;
      end else begin
        state <= ST_IDLE;
        wr_en <= 1'b0;
      end
    end
  end

`ifdef PE_WB_BYPASS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_data0 <= '0;
      byp_data1 <= '0;
      byp_op0   <= '0;
      byp_op1   <= '0;
      byp_vld   <= '0;
    end else if (push) begin
      byp_data1 <= byp_data0;
      byp_data0 <= pe_data;
      byp_op1   <= byp_op0;
      byp_op0   <= pe_opcode;
      byp_vld   <= {byp_vld[0], 1'b1};
    end
  end
`else
  assign byp_data0 = '0;
  assign byp_data1 = '0;
  assign byp_op0   = '0;
  assign byp_op1   = '0;
  assign byp_vld   = '0;
`endif

endmodule

// File: tb/tb_pe_writeback.sv
// tb/tb_pe_writeback.sv - scoreboard bench for pe_writeback against a lane-level reference model
module tb_pe_writeback;

  localparam int P  = 256;
  localparam int Q  = 6;
  localparam int AW = 9;
  localparam int HW = P * Q;

  logic              clk = 1'b0;
  logic              rst;
  logic              pe_valid;
  logic              pe_ready;
  logic [2*HW-1:0]   pe_data;
  logic [3:0]        pe_opcode;
  logic [AW-1:0]     pe_addr;
  logic [10:0]       pe_inv;
  logic              wr_en;
  logic              wr_ready;
  logic              wr_beta;
  logic [AW-1:0]     wr_addr;
  logic [HW-1:0]     wr_data;
  logic [P-1:0]      wr_mask;
  logic [2*HW-1:0]   byp_data0;
  logic [2*HW-1:0]   byp_data1;
  logic [3:0]        byp_op0;
  logic [3:0]        byp_op1;
  logic [1:0]        byp_vld;
  logic              busy;

  pe_writeback #(.P(P), .Q(Q), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .pe_valid  (pe_valid),
    .pe_ready  (pe_ready),
    .pe_data   (pe_data),
    .pe_opcode (pe_opcode),
    .pe_addr   (pe_addr),
    .pe_inv    (pe_inv),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .wr_beta   (wr_beta),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .byp_data0 (byp_data0),
    .byp_data1 (byp_data1),
    .byp_op0   (byp_op0),
    .byp_op1   (byp_op1),
    .byp_vld   (byp_vld),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          beta;
    logic [AW-1:0] addr;
    logic [HW-1:0] data;
    logic [P-1:0]  mask;
  } wr_t;

  wr_t             exp_q[$];
  int              total = 0;
  int              bad = 0;
  int              nwr = 0;
  bit              rand_rdy = 1'b0;
  logic [2*HW-1:0] hist0 = '0;
  logic [2*HW-1:0] hist1 = '0;
  logic [3:0]      hop0 = '0;
  logic [3:0]      hop1 = '0;
  logic [1:0]      hvld = '0;

  task automatic chk(input bit ok, input string what);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s", what);
    end
  endtask

  // Reference: lane-by-lane placement straight from the node-size rules.
  function automatic void model(input logic [2*HW-1:0] d, input logic [3:0] op,
                                input logic [AW-1:0] a, input logic [10:0] inv);
    bit  legal = 1'b0;
    int  n;
    int  src;
    wr_t w;
    for (int k = 1; k <= 10; k++)
      if (int'(inv) == (1 << k)) legal = 1'b1;
    if (op > 4'd3) legal = 1'b0;
    if (op <= 4'd1 && int'(inv) < 4) legal = 1'b0;
    if (!legal) return;
    w.data = '0;
    w.mask = '0;
    w.addr = a;
    w.beta = (op >= 4'd2);
    if (op <= 4'd1) begin
      n   = int'(inv) / 4;
      src = (op == 4'd1) ? HW : 0;
      for (int i = 0; i < n; i++) begin
        w.data[i*Q +: Q] = d[src + i*Q +: Q];
        w.mask[i] = 1'b1;
      end
      exp_q.push_back(w);
    end else if (int'(inv) >= 512) begin
      w.data = d[HW-1:0];
      w.mask = '1;
      exp_q.push_back(w);
      w.addr = AW'((int'(a) + 1) % (1 << AW));
      w.data = d[2*HW-1:HW];
      exp_q.push_back(w);
    end else if (op == 4'd2 && int'(inv) == 2) begin
      for (int i = 0; i < 2; i++) begin
        w.data[i*Q +: Q] = d[i*Q +: Q];
        w.mask[i] = 1'b1;
      end
      exp_q.push_back(w);
    end else begin
      n = int'(inv) / 2;
      for (int i = 0; i < n; i++) begin
        w.data[i*Q +: Q]     = d[i*Q +: Q];
        w.data[(n+i)*Q +: Q] = d[HW + i*Q +: Q];
        w.mask[i]   = 1'b1;
        w.mask[n+i] = 1'b1;
      end
      exp_q.push_back(w);
    end
  endfunction

  function automatic logic [2*HW-1:0] rnd_data();
    logic [2*HW-1:0] d;
    for (int i = 0; i < 2*HW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic check_byp();
`ifdef PE_WB_BYPASS_EN
    chk(byp_data0 === hist0, "byp_data0 differs from latest accepted result");
    chk(byp_data1 === hist1, "byp_data1 differs from previous accepted result");
    chk(byp_op0 === hop0 && byp_op1 === hop1,
        $sformatf("byp_op got %0d/%0d want %0d/%0d", byp_op0, byp_op1, hop0, hop1));
    chk(byp_vld === hvld, $sformatf("byp_vld got %b want %b", byp_vld, hvld));
`else
    chk(byp_data0 === '0 && byp_data1 === '0, "byp_data nonzero without bypass history");
    chk(byp_op0 === 4'd0 && byp_op1 === 4'd0 && byp_vld === 2'b00,
        $sformatf("byp_op/vld got %0d/%0d/%b want 0/0/00", byp_op0, byp_op1, byp_vld));
`endif
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic offer(input logic [2*HW-1:0] d, input logic [3:0] op,
                       input logic [AW-1:0] a, input logic [10:0] inv, input int max_wait);
    int w = 0;
    bit accepted = 1'b0;
    pe_valid  = 1'b1;
    pe_data   = d;
    pe_opcode = op;
    pe_addr   = a;
    pe_inv    = inv;
    while (!accepted && w <= max_wait) begin
      @(negedge clk);
      if (pe_ready) begin
        model(d, op, a, inv);
        hist1 = hist0;
        hop1  = hop0;
        hist0 = d;
        hop0  = op;
        hvld  = {hvld[0], 1'b1};
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
      w++;
    end
    pe_valid = 1'b0;
    chk(accepted, $sformatf("accept op=%0d inv=%0d accepted=%0b want 1", op, inv, accepted));
    if (accepted) check_byp();
  endtask

  task automatic drain(input int max_cyc);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < max_cyc) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(exp_q.size() == 0 && !busy,
        $sformatf("drain pending=%0d busy=%0b want 0/0", exp_q.size(), busy));
  endtask

  // Monitor: every presented write must match the scoreboard head, also while stalled.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) begin
        chk(1'b0 == wr_en, $sformatf("unexpected write addr=%0d beta=%0b", wr_addr, wr_beta));
      end else begin
        wr_t e;
        int  bl;
        int  li;
        e  = exp_q[0];
        bl = -1;
        for (int i = P - 1; i >= 0; i--)
          if (wr_data[i*Q +: Q] !== e.data[i*Q +: Q]) bl = i;
        li = (bl < 0) ? 0 : bl;
        chk(wr_beta === e.beta, $sformatf("wr_beta got %0b want %0b", wr_beta, e.beta));
        chk(wr_addr === e.addr, $sformatf("wr_addr got %0d want %0d", wr_addr, e.addr));
        chk(wr_mask === e.mask, $sformatf("wr_mask got %h want %h", wr_mask, e.mask));
        chk(bl < 0, $sformatf("wr_data lane %0d got %h want %h", li,
                              wr_data[li*Q +: Q], e.data[li*Q +: Q]));
        if (wr_ready) begin
          void'(exp_q.pop_front());
          nwr++;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      wr_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [2*HW-1:0] d;
    logic [3:0]      op;
    logic [10:0]     inv;
    int              r;
    rst       = 1'b1;
    pe_valid  = 1'b0;
    pe_data   = '0;
    pe_opcode = '0;
    pe_addr   = '0;
    pe_inv    = 11'd2;
    wr_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(wr_en === 1'b0 && busy === 1'b0 && pe_ready === 1'b1,
        $sformatf("reset wr_en/busy/pe_ready got %b%b%b want 001", wr_en, busy, pe_ready));
    chk(wr_data === '0 && wr_addr === '0 && wr_mask === '0 && wr_beta === 1'b0,
        "reset wr_data/addr/mask/beta nonzero");
    chk(byp_vld === 2'b00 && byp_data0 === '0, $sformatf("reset byp_vld got %b want 00", byp_vld));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // TYPE1, I_Nv=256: 64 lanes of a constant from the low half, write one cycle after accept.
    d = rnd_data();
    for (int i = 0; i < P; i++) d[i*Q +: Q] = 6'h2A;
    offer(d, 4'd0, 9'd5, 11'd256, 20);
    chk(wr_en === 1'b1, $sformatf("latency wr_en one cycle after accept got %b want 1", wr_en));
    drain(50);

    // Split with address wrap, then the unsplit 128-node beta packing.
    offer(rnd_data(), 4'd3, 9'd511, 11'd512, 20);
    drain(50);
    offer(rnd_data(), 4'd3, 9'd40, 11'd128, 20);
    offer(rnd_data(), 4'd1, 9'd7, 11'd64, 20);
    offer(rnd_data(), 4'd2, 9'd9, 11'd2, 20);
    offer(rnd_data(), 4'd2, 9'd10, 11'd1024, 20);
    drain(50);

    // Illegal node sizes are consumed without any write.
    offer(rnd_data(), 4'd3, 9'd1, 11'd3, 20);
    offer(rnd_data(), 4'd0, 9'd2, 11'd2, 20);
    drain(50);

    // Stall the second half of a split while more results arrive.
    offer(rnd_data(), 4'd3, 9'd100, 11'd512, 20);
    @(posedge clk);
    #1;
    wr_ready = 1'b0;
    offer(rnd_data(), 4'd0, 9'd101, 11'd16, 20);
    chk(pe_ready === 1'b0, $sformatf("pe_ready with two queued got %b want 0", pe_ready));
    fork
      offer(rnd_data(), 4'd3, 9'd102, 11'd8, 50);
      begin
        repeat (2) @(posedge clk);
        #1;
        wr_ready = 1'b1;
      end
    join
    drain(50);

    // Reset while the high half of a split is presented.
    offer(rnd_data(), 4'd3, 9'd200, 11'd1024, 20);
    offer(rnd_data(), 4'd0, 9'd201, 11'd32, 20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    hist0 = '0;
    hist1 = '0;
    hop0  = '0;
    hop1  = '0;
    hvld  = '0;
    chk(wr_en === 1'b0 && busy === 1'b0 && pe_ready === 1'b1,
        $sformatf("post-reset wr_en/busy/pe_ready got %b%b%b want 001", wr_en, busy, pe_ready));
    check_byp();
    repeat (4) @(posedge clk);
    #1;
    chk(busy === 1'b0, $sformatf("busy after aborted burst got %b want 0", busy));

    // Randomized traffic with random write back-pressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 120; n++) begin
      r   = $urandom_range(0, 19);
      op  = (r == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      inv = (r == 1) ? 11'($urandom_range(0, 2047)) : 11'(1 << $urandom_range(1, 10));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      offer(rnd_data(), op, AW'($urandom), inv, 200);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    wr_ready = 1'b1;
    drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
